// File: rtl/axis_rr_arb_2to1_if.sv
// Stream bundle for the 2:1 round-robin packet arbiter: two upstream ports,
// one downstream port, plus grant status.
interface axis_rr_arb_2to1_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] data_0;
  logic             valid_0;
  logic             last_0;
  logic             ready_0;

  logic [WIDTH-1:0] data_1;
  logic             valid_1;
  logic             last_1;
  logic             ready_1;

  logic [WIDTH-1:0] data;
  logic             valid;
  logic             last;
  logic             ready;

  logic             sel;
  logic             busy;

  // arbiter side
  modport slave (
    input  data_0, valid_0, last_0,
    output ready_0,
    input  data_1, valid_1, last_1,
    output ready_1,
    output data, valid, last,
    input  ready,
    output sel, busy
  );

  // environment side: upstream sources and downstream sink
  modport master (
    output data_0, valid_0, last_0,
    input  ready_0,
    output data_1, valid_1, last_1,
    input  ready_1,
    input  data, valid, last,
    output ready,
    input  sel, busy
  );
endinterface

// File: rtl/axis_rr_arb_2to1.sv
// 2:1 round-robin packet arbiter: a grant is held for a whole packet and
// handed over on the last beat without an idle cycle.
//
//   state  | meaning
//   IDLE   | no grant held; outputs quiet, waiting for any valid
//   GRANT0 | port 0 owns the output until it transfers a last beat
//   GRANT1 | port 1 owns the output until it transfers a last beat
module axis_rr_arb_2to1 #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  axis_rr_arb_2to1_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   ptr_q, ptr_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    bus.ready_0 = 1'b0;
    bus.ready_1 = 1'b0;
    bus.data    = {WIDTH{1'b0}};
    bus.valid   = 1'b0;
    bus.last    = 1'b0;
    bus.sel     = ptr_q;
    bus.busy    = 1'b0;

    unique case (state_q)
      IDLE: begin
        // ptr only breaks ties; it is not moved by the first grant
        if (bus.valid_0 && (!bus.valid_1 || !ptr_q)) begin
          state_d = GRANT0;
        end else if (bus.valid_1) begin
          state_d = GRANT1;
        end
      end

      GRANT0: begin
        bus.data    = bus.data_0;
        bus.valid   = bus.valid_0;
        bus.last    = bus.last_0;
        bus.ready_0 = bus.ready;
        bus.sel     = 1'b0;
        bus.busy    = 1'b1;
        if (bus.valid_0 && bus.ready && bus.last_0) begin
          ptr_d = 1'b1;
          if (bus.valid_1) begin
            state_d = GRANT1;
          end else if (bus.valid_0) begin
            state_d = GRANT0;
          end else begin
            state_d = IDLE;
          end
        end
      end

      GRANT1: begin
        bus.data    = bus.data_1;
        bus.valid   = bus.valid_1;
        bus.last    = bus.last_1;
        bus.ready_1 = bus.ready;
        bus.sel     = 1'b1;
        bus.busy    = 1'b1;
        if (bus.valid_1 && bus.ready && bus.last_1) begin
          ptr_d = 1'b0;
          if (bus.valid_0) begin
            state_d = GRANT0;
          end else if (bus.valid_1) begin
            state_d = GRANT1;
          end else begin
            state_d = IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_axis_rr_arb_2to1.sv
// Directed bench for axis_rr_arb_2to1: queued packet sources per port and a
// scoreboard monitor that checks every downstream beat in hand-computed order.
module tb_axis_rr_arb_2to1;
  localparam int WIDTH = 16;

  typedef struct {
    logic [WIDTH-1:0] data;
    logic             last;
  } beat_t;

  typedef struct {
    logic [WIDTH-1:0] data;
    logic             last;
    logic             sel;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  axis_rr_arb_2to1_if #(.WIDTH(WIDTH)) bus ();

  axis_rr_arb_2to1 #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  beat_t q0[$];
  beat_t q1[$];
  exp_t  exp_q[$];
  logic  hold0 = 1'b0;
  logic  hold1 = 1'b0;
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    cyc0 = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic drive();
    bus.valid_0 = (q0.size() > 0) && !hold0;
    bus.data_0  = (q0.size() > 0) ? q0[0].data : '0;
    bus.last_0  = (q0.size() > 0) ? q0[0].last : 1'b0;
    bus.valid_1 = (q1.size() > 0) && !hold1;
    bus.data_1  = (q1.size() > 0) ? q1[0].data : '0;
    bus.last_1  = (q1.size() > 0) ? q1[0].last : 1'b0;
  endtask

  // one clock: sample handshakes mid-cycle, advance sources just after the edge
  task automatic tick();
    logic f0, f1;
    @(negedge clk);
    f0 = bus.valid_0 && bus.ready_0;
    f1 = bus.valid_1 && bus.ready_1;
    @(posedge clk);
    #1;
    cyc++;
    if (f0 === 1'b1) q0.delete(0);
    if (f1 === 1'b1) q1.delete(0);
    drive();
  endtask

  task automatic add_pkt(input int port, input logic [WIDTH-1:0] base, input int n);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.data = base + WIDTH'(i);
      b.last = (i == n - 1);
      if (port == 0) q0.push_back(b);
      else q1.push_back(b);
    end
  endtask

  task automatic expect_beat(input logic [WIDTH-1:0] d, input logic l, input logic s);
    exp_t e;
    e.data = d;
    e.last = l;
    e.sel  = s;
    exp_q.push_back(e);
  endtask

  task automatic expect_pkt(input logic [WIDTH-1:0] base, input int n, input logic s);
    for (int i = 0; i < n; i++) expect_beat(base + WIDTH'(i), i == n - 1, s);
  endtask

  task automatic drain(input string name, input int max);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < max) begin
      tick();
      n++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: %0d beats outstanding, expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic do_reset();
    q0.delete();
    q1.delete();
    hold0 = 1'b0;
    hold1 = 1'b0;
    bus.ready = 1'b1;
    rst = 1'b1;
    drive();
    tick();
    rst = 1'b0;
    drive();
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    exp_t e;
    if (bus.busy === 1'b1)
      chk("nongrant_ready", bus.sel ? bus.ready_0 : bus.ready_1, 32'd0);
    if (bus.valid === 1'b1 && bus.ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat: got data %0h, expected none", bus.data);
      end else begin
        e = exp_q.pop_front();
        chk("out_data", bus.data, e.data);
        chk("out_last", bus.last, e.last);
        chk("out_sel", bus.sel, e.sel);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // reset with both ports requesting: IDLE outputs must stay quiet
    rst = 1'b1;
    bus.ready = 1'b1;
    add_pkt(0, 16'h0A00, 2);
    add_pkt(1, 16'h1A00, 2);
    drive();
    tick();
    tick();
    #1;
    chk("rst_busy", bus.busy, 0);
    chk("rst_valid", bus.valid, 0);
    chk("rst_last", bus.last, 0);
    chk("rst_data", bus.data, 0);
    chk("rst_ready_0", bus.ready_0, 0);
    chk("rst_ready_1", bus.ready_1, 0);
    chk("rst_sel", bus.sel, 0);

    // both ports, 3-beat packets: port 0 then port 1 with no gap
    do_reset();
    add_pkt(0, 16'h0100, 3);
    add_pkt(1, 16'h1100, 3);
    expect_pkt(16'h0100, 3, 1'b0);
    expect_pkt(16'h1100, 3, 1'b1);
    cyc0 = cyc;
    drive();
    drain("s1", 20);
    chk("s1_cycles", cyc - cyc0, 7);

    // port 0 back-to-back, port 1 joins mid-packet
    do_reset();
    hold1 = 1'b1;
    add_pkt(0, 16'h0200, 2);
    add_pkt(0, 16'h0210, 2);
    add_pkt(0, 16'h0220, 2);
    add_pkt(1, 16'h1200, 2);
    expect_pkt(16'h0200, 2, 1'b0);
    expect_pkt(16'h0210, 2, 1'b0);
    expect_pkt(16'h1200, 2, 1'b1);
    expect_pkt(16'h0220, 2, 1'b0);
    cyc0 = cyc;
    drive();
    repeat (4) tick();
    hold1 = 1'b0;
    drive();
    drain("s2", 20);
    chk("s2_cycles", cyc - cyc0, 9);

    // downstream ready toggling during a 4-beat port 1 packet
    do_reset();
    add_pkt(1, 16'h1300, 4);
    expect_pkt(16'h1300, 4, 1'b1);
    cyc0 = cyc;
    bus.ready = 1'b1;
    drive();
    tick();
    for (int i = 2; i <= 12 && exp_q.size() > 0; i++) begin
      bus.ready = (i % 2 == 0);
      tick();
      chk("s3_ready_0", bus.ready_0, 0);
    end
    chk("s3_cycles", cyc - cyc0, 8);
    chk("s3_outstanding", exp_q.size(), 0);
    exp_q.delete();
    bus.ready = 1'b1;

    // port 0 valid gap mid-packet while port 1 waits
    do_reset();
    add_pkt(0, 16'h0400, 4);
    add_pkt(1, 16'h1400, 2);
    expect_pkt(16'h0400, 4, 1'b0);
    expect_pkt(16'h1400, 2, 1'b1);
    cyc0 = cyc;
    drive();
    repeat (3) tick();
    hold0 = 1'b1;
    drive();
    repeat (2) begin
      #2;
      chk("s4_busy", bus.busy, 1);
      chk("s4_sel", bus.sel, 0);
      chk("s4_ready_1", bus.ready_1, 0);
      tick();
    end
    hold0 = 1'b0;
    drive();
    drain("s4", 20);
    chk("s4_cycles", cyc - cyc0, 9);

    // single-beat packets on both ports alternate every cycle
    do_reset();
    for (int i = 0; i < 4; i++) begin
      add_pkt(0, 16'h0500 + 16'(i), 1);
      add_pkt(1, 16'h1500 + 16'(i), 1);
      expect_pkt(16'h0500 + 16'(i), 1, 1'b0);
      expect_pkt(16'h1500 + 16'(i), 1, 1'b1);
    end
    cyc0 = cyc;
    drive();
    drain("s5", 20);
    chk("s5_cycles", cyc - cyc0, 9);

    // reset during the second beat of a port 1 packet
    do_reset();
    add_pkt(1, 16'h1600, 3);
    expect_beat(16'h1600, 1'b0, 1'b1);
    expect_pkt(16'h0600, 2, 1'b0);
    expect_beat(16'h1601, 1'b0, 1'b1);
    expect_beat(16'h1602, 1'b1, 1'b1);
    drive();
    tick();
    tick();
    bus.ready = 1'b0;
    rst = 1'b1;
    #2;
    chk("s6_busy_during_rst", bus.busy, 1);
    chk("s6_valid_during_rst", bus.valid, 1);
    tick();
    rst = 1'b0;
    bus.ready = 1'b1;
    add_pkt(0, 16'h0600, 2);
    drive();
    #2;
    chk("s6_busy_after_rst", bus.busy, 0);
    chk("s6_valid_after_rst", bus.valid, 0);
    chk("s6_ready_1_after_rst", bus.ready_1, 0);
    drain("s6", 20);

    chk("src0_empty", q0.size(), 0);
    chk("src1_empty", q1.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axis_rr_arb_2to1.md
AXIS_RR_ARB_2TO1 -- requirements
Module: axis_rr_arb_2to1

Interface
REQ-001 Parameter WIDTH, default 16, data width of every stream.
REQ-002 clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 data_0  input  WIDTH  port 0 payload.
REQ-005 valid_0  input  1  port 0 beat valid.
REQ-006 last_0  input  1  port 0 end-of-packet marker.
REQ-007 ready_0  output  1  port 0 accept.
REQ-008 data_1, valid_1, last_1, ready_1: same as REQ-004..007 for port 1.
REQ-009 data  output  WIDTH  arbitrated payload.
REQ-010 valid  output  1  arbitrated beat valid.
REQ-011 last  output  1  arbitrated end-of-packet.
REQ-012 ready  input  1  downstream accept.
REQ-013 sel  output  1  currently granted port; meaningful only while busy=1.
REQ-014 busy  output  1  high while a grant is held (state GRANT0 or GRANT1).

Function
REQ-015 States: IDLE, GRANT0, GRANT1; registered state plus a 1-bit registered priority pointer ptr, the port preferred on contention.
REQ-016 Transfer on port k: valid_k and ready_k both high on a clock edge.
REQ-017 IDLE: ready_0=ready_1=0, valid=0, last=0, data=0, busy=0, sel=ptr.
REQ-018 IDLE next state: only valid_0 -> GRANT0; only valid_1 -> GRANT1; both -> GRANT<ptr>; neither -> IDLE.
REQ-019 Arbitration latency: the first beat of a packet passes downstream no earlier than one cycle after its valid is seen in IDLE.
REQ-020 GRANTk: data=data_k, valid=valid_k, last=last_k, ready_k=ready, ready of the other port=0, sel=k, busy=1; combinational pass-through, zero added beat latency.
REQ-021 GRANTk holds for every non-last transfer; valid_k deasserting mid-packet does not release the grant.
REQ-022 GRANTk, transfer with last_k=1: ptr <= ~k, and the next state is chosen in the same cycle without an IDLE bubble: valid of the other port -> GRANT<~k>; else valid_k -> GRANTk; else IDLE.
REQ-023 The next-state choice in REQ-022 samples the other port's valid and port k's valid in the cycle of the last transfer.
REQ-024 The non-granted port never sees ready high; no beat is ever dropped or duplicated; packets never interleave on the output.
REQ-025 ptr updates only on a last transfer; in IDLE, the first grant does not change ptr.
REQ-026 A single-beat packet (last high on its first beat) follows REQ-022 like any other packet.
REQ-027 ready low in GRANTk: all outputs hold their pass-through values; state and ptr do not change.

Reset
REQ-028 rst=1 at a clock edge: state <= IDLE, ptr <= 0; outputs take the REQ-017 values from the next cycle on.
REQ-029 rst mid-packet: the grant is abandoned; after rst deasserts, arbitration restarts per REQ-018 with ptr=0.
REQ-030 Outputs do not depend on rst combinationally; reset takes effect only at a clock edge.

Verification
REQ-031 A bench SHALL cover at least the following directed scenarios:
- Both ports valid with 3-beat packets after reset, ready=1 -> port 0 packet (3 beats), then port 1 packet immediately, no idle cycle; sel 0 then 1.
- Port 0 streams back-to-back 2-beat packets, port 1 raises valid mid-packet -> port 0's current packet completes, port 1's packet follows, then port 0 resumes.
- ready toggled 1,0,1,0 during a 4-beat port 1 packet -> the output carries exactly 4 beats in order; ready_0=0 throughout.
- valid_0 drops for 2 cycles mid-packet while valid_1=1 -> grant stays GRANT0 and the remaining port 0 beats complete before port 1 starts.
- Single-beat packets alternate on both ports continuously -> output ports alternate 0,1,0,1 with one beat per cycle.
- rst pulsed during the second beat of a port 1 packet -> next cycle busy=0, valid=0; with both valid afterwards, port 0 is granted first.
